// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control stage: ALU control codes,
// ALUOp encodings from main control and R-type funct values.
package alu_ctrl_pkg;

  // ALU control codes driven to the ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // ALUOp encodings produced by the main control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // lw / sw address add
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // look at funct
  localparam logic [1:0] ALUOP_BAD   = 2'b11;  // never legal

  // R-type funct field values (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct -> ALU control code decoder.
// Unknown encodings produce ALU_AND (0000) with illegal raised.
// Build option: define ALU_NOR_EN to accept funct 100111 as a legal NOR.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] code,
  output logic       illegal
);

  // Decode table; defaults give the illegal/0000 result for anything unmatched.
  always_comb begin
    code    = ALU_AND;
    illegal = 1'b1;
    case (aluop)
      ALUOP_ADD: begin
        code    = ALU_ADD;
        illegal = 1'b0;
      end
      ALUOP_SUB: begin
        code    = ALU_SUB;
        illegal = 1'b0;
      end
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: begin code = ALU_ADD; illegal = 1'b0; end
          FUNCT_SUB: begin code = ALU_SUB; illegal = 1'b0; end
          FUNCT_AND: begin code = ALU_AND; illegal = 1'b0; end
          FUNCT_OR:  begin code = ALU_OR;  illegal = 1'b0; end
          FUNCT_SLT: begin code = ALU_SLT; illegal = 1'b0; end
`ifdef ALU_NOR_EN
          FUNCT_NOR: begin code = ALU_NOR; illegal = 1'b0; end
`endif
          default: begin
            code    = ALU_AND;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        code    = ALU_AND;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ALU control stage: decodes ID-stage ALUOp/funct, holds the result in an
// ID/EX register with stall/flush, resolves beq from the ALU zero flag and
// keeps a saturating count of accepted illegal encodings.
// Build option: ALU_NOR_EN (see alu_ctrl_decode) makes funct 100111 a legal NOR.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       id_aluop,
  input  logic [5:0]       id_funct,
  input  logic             id_branch,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [3:0]       ex_alucontrol,
  output logic             ex_branch,
  output logic             ex_illegal,
  input  logic             alu_zero,
  output logic             branch_taken,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       dec_code;
  logic             dec_illegal;

  logic             valid_reg;
  logic [3:0]       code_reg;
  logic             branch_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] count_reg;

  alu_ctrl_decode u_decode (
    .aluop   (id_aluop),
    .funct   (id_funct),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  // ID/EX register: reset, then flush (bubble), then stall (hold), else load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      code_reg    <= ALU_AND;
      branch_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else if (flush) begin
      valid_reg   <= 1'b0;
      code_reg    <= ALU_AND;
      branch_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else if (!stall) begin
      valid_reg   <= id_valid;
      code_reg    <= id_valid ? dec_code : ALU_AND;
      branch_reg  <= id_branch & id_valid;
      illegal_reg <= dec_illegal & id_valid;
    end
  end

  // Illegal-op counter: only load cycles count, and it sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (!flush && !stall && id_valid && dec_illegal && count_reg != CNT_MAX) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign ex_valid      = valid_reg;
  assign ex_alucontrol = code_reg;
  assign ex_branch     = branch_reg;
  assign ex_illegal    = illegal_reg;
  assign illegal_count = count_reg;

  // An illegal op never redirects the PC, even if it claimed to be a branch.
  assign branch_taken  = valid_reg & branch_reg & ~illegal_reg & alu_zero;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage. Two instances share the stimulus:
// the default CNT_W=8 build and a CNT_W=2 build for counter saturation.
// Honours ALU_NOR_EN the same way the design does.
module tb_alu_ctrl_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [1:0] id_aluop;
  logic [5:0] id_funct;
  logic       id_branch;
  logic       stall;
  logic       flush;
  logic       alu_zero;

  logic       ex_valid, ex_branch, ex_illegal, branch_taken;
  logic [3:0] ex_alucontrol;
  logic [7:0] illegal_count;

  logic       ex_valid2, ex_branch2, ex_illegal2, branch_taken2;
  logic [3:0] ex_alucontrol2;
  logic [1:0] illegal_count2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_ctrl_stage #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_aluop(id_aluop),
    .id_funct(id_funct), .id_branch(id_branch), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alucontrol(ex_alucontrol), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal), .alu_zero(alu_zero), .branch_taken(branch_taken),
    .illegal_count(illegal_count)
  );

  alu_ctrl_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_aluop(id_aluop),
    .id_funct(id_funct), .id_branch(id_branch), .stall(stall), .flush(flush),
    .ex_valid(ex_valid2), .ex_alucontrol(ex_alucontrol2), .ex_branch(ex_branch2),
    .ex_illegal(ex_illegal2), .alu_zero(alu_zero), .branch_taken(branch_taken2),
    .illegal_count(illegal_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step(input string what);
    @(posedge clk);
    #1;
    $display("vec %-12s v=%0b code=%h br=%0b ill=%0b cnt=%0d cnt2=%0d",
             what, ex_valid, ex_alucontrol, ex_branch, ex_illegal,
             illegal_count, illegal_count2);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn, input logic br);
    id_valid  = v;
    id_aluop  = op;
    id_funct  = fn;
    id_branch = br;
  endtask

  logic [5:0] rt_funct [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [3:0] rt_code  [5] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7};
  int exp_cnt;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; alu_zero = 1'b0;
    drive(1'b0, 2'b00, 6'h00, 1'b0);
    #2;

    // Reset state
    step("reset");
    chk("rst_valid", ex_valid, 0);
    chk("rst_code", ex_alucontrol, 0);
    chk("rst_branch", ex_branch, 0);
    chk("rst_illegal", ex_illegal, 0);
    chk("rst_count", illegal_count, 0);
    chk("rst_count2", illegal_count2, 0);
    rst = 1'b0;
    exp_cnt = 0;

    // R-type sweep
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b10, rt_funct[i], 1'b0);
      step("rtype");
      chk("rt_code", ex_alucontrol, rt_code[i]);
      chk("rt_valid", ex_valid, 1);
      chk("rt_illegal", ex_illegal, 0);
    end

    // lw/sw add
    drive(1'b1, 2'b00, 6'h3F, 1'b0);
    step("lw");
    chk("lw_code", ex_alucontrol, 4'h2);

    // beq resolution
    drive(1'b1, 2'b01, 6'h00, 1'b1);
    step("beq");
    chk("beq_code", ex_alucontrol, 4'h6);
    chk("beq_branch", ex_branch, 1);
    alu_zero = 1'b1; #1;
    chk("beq_taken", branch_taken, 1);
    alu_zero = 1'b0; #1;
    chk("beq_not_taken", branch_taken, 0);

    // invalid slot: bubble, no branch even with zero set
    drive(1'b0, 2'b01, 6'h00, 1'b1);
    alu_zero = 1'b1;
    step("bubble");
    chk("bub_valid", ex_valid, 0);
    chk("bub_code", ex_alucontrol, 0);
    chk("bub_branch", ex_branch, 0);
    chk("bub_taken", branch_taken, 0);
    alu_zero = 1'b0;

    // stall holds for 3 cycles
    drive(1'b1, 2'b10, 6'h2A, 1'b0);
    step("pre_stall");
    chk("pre_stall_code", ex_alucontrol, 4'h7);
    drive(1'b1, 2'b10, 6'h20, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall_code", ex_alucontrol, 4'h7);
      chk("stall_valid", ex_valid, 1);
    end
    stall = 1'b0;
    step("unstall");
    chk("unstall_code", ex_alucontrol, 4'h2);

    // flush beats stall
    stall = 1'b1; flush = 1'b1;
    step("flush+stall");
    chk("flush_valid", ex_valid, 0);
    chk("flush_code", ex_alucontrol, 0);
    stall = 1'b0; flush = 1'b0;

    // illegal aluop=11 claiming to be a branch
    drive(1'b1, 2'b11, 6'h20, 1'b1);
    alu_zero = 1'b1;
    step("illegal");
    exp_cnt = 1;
    chk("ill_flag", ex_illegal, 1);
    chk("ill_code", ex_alucontrol, 0);
    chk("ill_count", illegal_count, exp_cnt);
    chk("ill_count2", illegal_count2, exp_cnt);
    chk("ill_no_taken", branch_taken, 0);
    alu_zero = 1'b0;

    // same op under stall, then under flush: no count
    stall = 1'b1;
    step("ill_stall");
    chk("ill_stall_count", illegal_count, 1);
    chk("ill_stall_flag", ex_illegal, 1);
    stall = 1'b0; flush = 1'b1;
    step("ill_flush");
    chk("ill_flush_count", illegal_count, 1);
    chk("ill_flush_flag", ex_illegal, 0);
    flush = 1'b0;

    // 5 more illegal loads: 8-bit counts to 6, 2-bit sticks at 3
    drive(1'b1, 2'b10, 6'h3F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("ill_burst");
      exp_cnt++;
      chk("burst_count", illegal_count, exp_cnt);
      chk("burst_count2", illegal_count2, (exp_cnt > 3) ? 3 : exp_cnt);
    end

    // NOR option
    drive(1'b1, 2'b10, 6'h27, 1'b0);
    step("nor");
`ifdef ALU_NOR_EN
    chk("nor_code", ex_alucontrol, 4'hC);
    chk("nor_illegal", ex_illegal, 0);
    chk("nor_count", illegal_count, 6);
`else
    chk("nor_code", ex_alucontrol, 4'h0);
    chk("nor_illegal", ex_illegal, 1);
    chk("nor_count", illegal_count, 7);
`endif
    chk("nor_count2", illegal_count2, 3);

    // reset in the middle of a stall with valid state and nonzero count
    drive(1'b1, 2'b01, 6'h00, 1'b1);
    step("pre_rst");
    chk("pre_rst_valid", ex_valid, 1);
    stall = 1'b1; rst = 1'b1; alu_zero = 1'b1;
    step("rst_stall");
    chk("rs_valid", ex_valid, 0);
    chk("rs_code", ex_alucontrol, 0);
    chk("rs_branch", ex_branch, 0);
    chk("rs_illegal", ex_illegal, 0);
    chk("rs_count", illegal_count, 0);
    chk("rs_count2", illegal_count2, 0);
    chk("rs_taken", branch_taken, 0);
    rst = 1'b0; stall = 1'b0; alu_zero = 1'b0;

    // count restarts from 0 after reset
    drive(1'b1, 2'b11, 6'h00, 1'b0);
    step("post_rst_ill");
    chk("post_rst_count", illegal_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
